// File: rtl/pusch_pkg.sv
// Shared widths, frame limits and read-FSM encoding for the PUSCH ping-pong symbol buffer.
package pusch_pkg;
  localparam int DATA_WIDTH = 18;
  localparam int ADDR_WIDTH = 11;
  localparam int MAX_SYM    = 1200;
  localparam int DEPTH      = MAX_SYM + 1;
  localparam int WORD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} rd_state_t;
endpackage

// File: rtl/pusch_pp_ram.sv
// Two banks of simple dual-port RAM holding {I,Q} words; write and read pick banks independently.
module pusch_pp_ram
  import pusch_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_wbank,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic                  i_rbank,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WORD_WIDTH-1:0] o_rdata
);
  logic [WORD_WIDTH-1:0] w_bank_q [2];
  logic                  r_rsel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [WORD_WIDTH-1:0] r_mem [DEPTH];
      logic [WORD_WIDTH-1:0] r_q;
      always_ff @(posedge clk) begin
        if (i_we && (i_wbank == 1'(gi)))
          r_mem[i_waddr] <= i_wdata;
        if (i_re && (i_rbank == 1'(gi)))
          r_q <= r_mem[i_raddr];
      end
      assign w_bank_q[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_re)
      r_rsel <= i_rbank;
  end

  assign o_rdata = w_bank_q[r_rsel];
endmodule

// File: rtl/pusch_pingpong_buffer.sv
// Ping-pong symbol buffer: mapper fills one bank while the committed bank streams out over valid/ready.
module pusch_pingpong_buffer
  import pusch_pkg::*;
(
  input  logic                  CLK_PP,
  input  logic                  RST_PP,
  input  logic                  Wr_Valid,
  input  logic                  Wr_En,
  input  logic [ADDR_WIDTH-1:0] Wr_addr,
  input  logic [DATA_WIDTH-1:0] Wr_I,
  input  logic [DATA_WIDTH-1:0] Wr_Q,
  input  logic                  Switch,
  input  logic [ADDR_WIDTH-1:0] Last_addr,
  input  logic                  Rd_Ready,
  output logic                  Rd_Valid,
  output logic [DATA_WIDTH-1:0] Rd_I,
  output logic [DATA_WIDTH-1:0] Rd_Q,
  output logic                  Rd_Last,
  output logic [ADDR_WIDTH-1:0] Rd_Len,
  output logic [1:0]            Bank_Full,
  output logic                  Wr_Bank,
  output logic                  Overflow
);
  rd_state_t             r_state, w_state_next;
  logic                  r_wr_bank, r_rd_bank, r_ovf;
  logic [1:0]            r_bank_full;
  logic [ADDR_WIDTH-1:0] r_len [2];
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_rd_len;
  logic                  r_inflight, r_inflight_last;
  logic [WORD_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_fifo_rptr, r_fifo_wptr;
  logic [1:0]            r_fifo_count;

  logic [WORD_WIDTH-1:0] w_ram_q;
  logic                  w_we, w_pop, w_issue, w_issue_last, w_free;
  logic                  w_switch, w_busy, w_commit;
  logic [1:0]            w_free_mask, w_commit_mask;
  logic [2:0]            w_occupancy;

  assign w_we         = Wr_Valid & Wr_En & (Wr_addr <= ADDR_WIDTH'(MAX_SYM));
  assign w_pop        = (r_fifo_count != 2'd0) & Rd_Ready;
  assign w_occupancy  = {1'b0, r_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue_last = (r_rd_addr == r_rd_len);
  assign w_free       = (r_state == DRAIN) & w_pop & r_fifo_last[r_fifo_rptr];

  // Both banks full means the write bank itself is full; a bank released this cycle may be re-committed.
  assign w_switch      = Switch & (Last_addr != '0);
  assign w_busy        = r_bank_full[r_wr_bank] & ~(w_free & (r_rd_bank == r_wr_bank));
  assign w_commit      = w_switch & ~w_busy;
  assign w_free_mask   = w_free   ? (2'b01 << r_rd_bank) : 2'b00;
  assign w_commit_mask = w_commit ? (2'b01 << r_wr_bank) : 2'b00;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      IDLE:    if (r_bank_full[r_rd_bank]) w_state_next = STREAM;
      STREAM: begin
        w_issue = (w_occupancy < 3'd2);
        if (w_issue && w_issue_last) w_state_next = DRAIN;
      end
      DRAIN:   if (w_free) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_PP) begin
    if (RST_PP) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_wr_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_ovf       <= 1'b0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
    end else begin
      r_ovf       <= w_switch & w_busy;
      r_bank_full <= (r_bank_full & ~w_free_mask) | w_commit_mask;
      if (w_commit) begin
        r_len[r_wr_bank] <= Last_addr;
        r_wr_bank        <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      r_rd_bank       <= 1'b0;
      r_rd_addr       <= '0;
      r_rd_len        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= 2'b00;
      r_fifo_rptr     <= 1'b0;
      r_fifo_wptr     <= 1'b0;
      r_fifo_count    <= 2'd0;
    end else begin
      if (r_state == IDLE && r_bank_full[r_rd_bank]) begin
        r_rd_len  <= r_len[r_rd_bank];
        r_rd_addr <= ADDR_WIDTH'(1);
      end else if (w_issue) begin
        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      if (w_free) r_rd_bank <= ~r_rd_bank;
      // RAM data lands one cycle after issue; the occupancy rule guarantees a free slot.
      if (r_inflight) begin
        r_fifo_data[r_fifo_wptr] <= w_ram_q;
        r_fifo_last[r_fifo_wptr] <= r_inflight_last;
        r_fifo_wptr              <= ~r_fifo_wptr;
      end
      if (w_pop) r_fifo_rptr <= ~r_fifo_rptr;
      r_fifo_count <= r_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  pusch_pp_ram u_ram (
    .clk     (CLK_PP),
    .i_we    (w_we),
    .i_wbank (r_wr_bank),
    .i_waddr (Wr_addr),
    .i_wdata ({Wr_I, Wr_Q}),
    .i_re    (w_issue),
    .i_rbank (r_rd_bank),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

  assign Rd_Valid     = (r_fifo_count != 2'd0);
  assign {Rd_I, Rd_Q} = r_fifo_data[r_fifo_rptr];
  assign Rd_Last      = Rd_Valid & r_fifo_last[r_fifo_rptr];
  assign Rd_Len       = r_rd_len;
  assign Bank_Full    = r_bank_full;
  assign Wr_Bank      = r_wr_bank;
  assign Overflow     = r_ovf;
endmodule
